usb_slave_fifo_responder: RTL

Synthesizable device-side model of the USB 3.0 controller's 16-bit synchronous slave FIFO port. It is the responder to our FPGA-side stream master. It drives the DMA Ready/Watermark flags and sinks written words into two emulated write sockets. It also serves one host command word through a read socket. It sits in on-FPGA loopback builds and in the block-level bench, and exposes every committed word on a monitor stream.

---
 rtl/usb_sfifo_pkg.sv | 33 +++
 rtl/sfifo_wr_socket.sv | 88 ++++++++
 rtl/usb_slave_fifo_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_sfifo_pkg.sv
// Shared definitions for the USB 3.0 slave FIFO responder.
// Holds socket address codes, FSM state encodings, host command opcodes
// and the monitor stream payload layout.
package usb_sfifo_pkg;

    localparam logic [1:0] SOCK_W0 = 2'b00;
    localparam logic [1:0] SOCK_W1 = 2'b01;
    localparam logic [1:0] SOCK_RD = 2'b10;

    localparam logic [15:0] CMD_GET_CONFIG   = 16'h0001;
    localparam logic [15:0] CMD_START_STREAM = 16'h0011;
    localparam logic [15:0] CMD_STOP_STREAM  = 16'h000f;

    typedef enum logic {
        W_ARMED,
        W_DRAIN
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ARMED,
        R_DONE
    } rd_state_e;

    // One committed-write record on the monitor stream
    typedef struct packed {
        logic        valid;
        logic        sock;
        logic        commit;
        logic [15:0] data;
    } mon_word_t;

endpackage

// File: rtl/sfifo_wr_socket.sv
// Emulated write socket: counts words into a buffer, commits on full or
// short packet, then holds not-ready for a drain period.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   wr, last     write strobe addressed to this socket, short-packet marker
//   accept_c     write captured this cycle
//   commit_c     this write commits the buffer
//   drop_c       write dropped (draining or full)
//   ready_c      raw ready flag
//   wm_c         raw watermark flag
module sfifo_wr_socket
    import usb_sfifo_pkg::*;
#(
    parameter int unsigned BUF_WORDS    = 512,
    parameter int unsigned WM_WORDS     = 4,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr,
    input  logic last,
    output logic accept_c,
    output logic commit_c,
    output logic drop_c,
    output logic ready_c,
    output logic wm_c
);
    localparam int unsigned CW = $clog2(BUF_WORDS + 1);
    localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    wr_state_e     state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // State and counters; reset starts in a full drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W_DRAIN;
            wcnt_q  <= '0;
            dcnt_q  <= DW'(DRAIN_CYCLES);
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next state, counters and per-cycle write outcome
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        dcnt_d   = dcnt_q;
        accept_c = 1'b0;
        commit_c = 1'b0;
        drop_c   = 1'b0;
        case (state_q)
            W_ARMED: begin
                if (wr) begin
                    if (wcnt_q == CW'(BUF_WORDS)) begin
                        drop_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        wcnt_d   = wcnt_q + CW'(1);
                        if (last || (wcnt_q == CW'(BUF_WORDS - 1))) begin
                            commit_c = 1'b1;
                            state_d  = W_DRAIN;
                            dcnt_d   = DW'(DRAIN_CYCLES);
                        end
                    end
                end
            end
            W_DRAIN: begin
                drop_c = wr;
                if (dcnt_q == '0) begin
                    state_d = W_ARMED;
                    wcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            default: state_d = W_DRAIN;
        endcase
    end

    assign ready_c = (state_q == W_ARMED);
    assign wm_c    = ready_c && (wcnt_q >= CW'(BUF_WORDS - WM_WORDS));

endmodule

// File: rtl/usb_slave_fifo_responder.sv
// Device-side model of the USB 3.0 controller 16-bit synchronous slave FIFO.
// Two write sockets sink master writes; one read socket returns a single
// injected command word followed by zeros. Every accepted write is echoed
// on the monitor stream.
// Ports:
//   USB_CLK, rst_n                 clock, async active-low reset
//   WR, RD, OE, LastWRData         master strobes
//   DMA0_Address                   socket select (00/01 write, 10 read)
//   DQ                             bidirectional data bus
//   DMA0_Ready/Watermark           delayed flags of the addressed write socket
//   DMA1_Ready/Watermark           delayed flags of the read socket
//   cmd_valid/cmd_data/cmd_ready   command injection handshake
//   mon_valid/sock/commit/data     monitor stream
//   ovf_err, bus_err               sticky error flags
module usb_slave_fifo_responder
    import usb_sfifo_pkg::*;
#(
    parameter int unsigned BUF_WORDS    = 512,
    parameter int unsigned WM_WORDS     = 4,
    parameter int unsigned FLAG_LAT     = 2,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic        USB_CLK,
    input  logic        rst_n,
    input  logic        WR,
    input  logic        RD,
    input  logic        OE,
    input  logic        LastWRData,
    input  logic [1:0]  DMA0_Address,
    inout  wire  [15:0] DQ,
    output logic        DMA0_Ready,
    output logic        DMA0_Watermark,
    output logic        DMA1_Ready,
    output logic        DMA1_Watermark,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        mon_valid,
    output logic        mon_sock,
    output logic        mon_commit,
    output logic [15:0] mon_data,
    output logic        ovf_err,
    output logic        bus_err
);
    localparam int unsigned FL_W = FLAG_LAT * 4;
    localparam int unsigned RP_W = RD_LAT * 16;

    logic wr_hit, wr0, wr1, rd_hit;
    logic acc0, acc1, cm0, cm1, drop0, drop1, rdy0, rdy1, wm0, wm1;

    assign wr_hit = WR && !DMA0_Address[1];
    assign wr0    = wr_hit && !DMA0_Address[0];
    assign wr1    = wr_hit && DMA0_Address[0];
    assign rd_hit = RD && (DMA0_Address == SOCK_RD);

    sfifo_wr_socket #(
        .BUF_WORDS(BUF_WORDS), .WM_WORDS(WM_WORDS), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_ws0 (
        .clk(USB_CLK), .rst_n(rst_n), .wr(wr0), .last(LastWRData),
        .accept_c(acc0), .commit_c(cm0), .drop_c(drop0), .ready_c(rdy0), .wm_c(wm0)
    );

    sfifo_wr_socket #(
        .BUF_WORDS(BUF_WORDS), .WM_WORDS(WM_WORDS), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_ws1 (
        .clk(USB_CLK), .rst_n(rst_n), .wr(wr1), .last(LastWRData),
        .accept_c(acc1), .commit_c(cm1), .drop_c(drop1), .ready_c(rdy1), .wm_c(wm1)
    );

    // Read socket state
    rd_state_e         rd_state_q, rd_state_d;
    logic              rd_seen_q, rd_seen_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              rd_fire_c;
    logic [15:0]       rd_word_c;
    logic [RD_LAT-1:0] rd_vld_q;
    logic [RP_W-1:0]   rd_pipe_q;
    logic [15:0]       dq_hold_q, dq_out_c;
    logic              dq_oe_c;

    // Flag mux: address 10 keeps showing the last write socket selected
    logic            sel_q, sel_c;
    logic [3:0]      raw_flags;
    logic [FL_W-1:0] flag_q;

    assign sel_c     = DMA0_Address[1] ? sel_q : DMA0_Address[0];
    assign raw_flags = {sel_c ? rdy1 : rdy0,
                        sel_c ? wm1 : wm0,
                        rd_state_q == R_ARMED,
                        (rd_state_q == R_ARMED) && rd_seen_q};

    // FLAG_LAT-deep flag delay line, newest sample in the low nibble
    always_ff @(posedge USB_CLK or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            flag_q <= '0;
        end else begin
            if (!DMA0_Address[1]) begin
                sel_q <= DMA0_Address[0];
            end
            flag_q <= (flag_q << 4) | FL_W'(raw_flags);
        end
    end

    assign {DMA0_Ready, DMA0_Watermark, DMA1_Ready, DMA1_Watermark} = flag_q[FL_W-1 -: 4];

    // Read socket next state; the first read returns the command word
    always_comb begin
        rd_state_d = rd_state_q;
        rd_seen_d  = rd_seen_q;
        cmd_d      = cmd_q;
        rd_fire_c  = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d      = cmd_data;
                    rd_state_d = R_ARMED;
                end
            end
            R_ARMED: begin
                if (rd_hit) begin
                    rd_fire_c = 1'b1;
                    rd_seen_d = 1'b1;
                end else if (rd_seen_q && !RD) begin
                    rd_state_d = R_DONE;
                end
            end
            R_DONE: begin
                if (rd_vld_q == '0) begin
                    rd_state_d = R_IDLE;
                    rd_seen_d  = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign rd_word_c = rd_seen_q ? 16'h0000 : cmd_q;

    always_ff @(posedge USB_CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_seen_q  <= 1'b0;
            cmd_q      <= '0;
            cmd_ready  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_seen_q  <= rd_seen_d;
            cmd_q      <= cmd_d;
            cmd_ready  <= (rd_state_d == R_IDLE);
        end
    end

    // RD_LAT-stage read pipeline plus a hold register that keeps the last
    // word on the bus until new data arrives or OE drops
    always_ff @(posedge USB_CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= '0;
            rd_pipe_q <= '0;
            dq_hold_q <= '0;
        end else begin
            rd_vld_q  <= (rd_vld_q << 1) | RD_LAT'(rd_fire_c);
            rd_pipe_q <= (rd_pipe_q << 16) | RP_W'(rd_word_c);
            if (rd_vld_q[RD_LAT-1]) begin
                dq_hold_q <= rd_pipe_q[RP_W-1 -: 16];
            end else if (!OE) begin
                dq_hold_q <= '0;
            end
        end
    end

    assign dq_out_c = rd_vld_q[RD_LAT-1] ? rd_pipe_q[RP_W-1 -: 16] : dq_hold_q;
    assign dq_oe_c  = rst_n && OE && !WR && (DMA0_Address == SOCK_RD);
    assign DQ       = dq_oe_c ? dq_out_c : 16'bz;

    // Monitor stream and sticky errors
    mon_word_t mon_q;

    always_ff @(posedge USB_CLK or negedge rst_n) begin
        if (!rst_n) begin
            mon_q   <= '0;
            ovf_err <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (acc0 || acc1) begin
                mon_q.valid  <= 1'b1;
                mon_q.sock   <= DMA0_Address[0];
                mon_q.commit <= cm0 || cm1;
                mon_q.data   <= DQ;
            end else begin
                mon_q.valid  <= 1'b0;
                mon_q.commit <= 1'b0;
            end
            ovf_err <= ovf_err || drop0 || drop1;
            bus_err <= bus_err || (WR && OE);
        end
    end

    assign mon_valid  = mon_q.valid;
    assign mon_sock   = mon_q.sock;
    assign mon_commit = mon_q.commit;
    assign mon_data   = mon_q.data;

endmodule
